// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Fills the instruction memory from a byte stream before the core is allowed
// to run. A frame is a big-endian 16-bit word count N, then N big-endian
// 16-bit words, then one checksum byte chosen so that the XOR of every frame
// byte comes to zero. Words are written to addresses 0..N-1 as they arrive.
// The core stays held until a frame has loaded and its checksum has passed.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse that begins a new frame (IDLE/DONE/ERROR)
//   rx_data       incoming byte
//   rx_valid      rx_data is valid
//   rx_ready      loader can accept a byte this cycle
//   wr_en         instruction-memory write strobe, one cycle per word
//   wr_addr       instruction-memory write address
//   wr_data       instruction-memory write word
//   busy          frame in progress
//   done          last frame loaded with a good checksum
//   err           last frame rejected (bad length or bad checksum)
//   word_count    words written in the current or last frame
//   cpu_hold      keep the core stalled; low only after a good load
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_H,
    LEN_L,
    DATA_H,
    DATA_L,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam logic [15:0] DepthW = 16'(DEPTH);

  state_t            state_q, state_d;
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic              wrEn_q, wrEn_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [15:0]       wrData_q, wrData_d;

  logic              accept;
  logic [15:0]       lenNew;
  logic [15:0]       idxNext16;

  // hi_q holds whichever high byte is pending: LEN_HI while in LEN_L,
  // the data HI byte while in DATA_L.
  assign lenNew    = {hi_q, rx_data};
  assign idxNext16 = 16'(idx_q) + 16'd1;
  assign accept    = rx_valid && rx_ready;

  // State and datapath registers; reset returns to IDLE and cancels any
  // write strobe that was about to be issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      xor_q    <= 8'h00;
      hi_q     <= 8'h00;
      len_q    <= 16'h0000;
      idx_q    <= '0;
      wc_q     <= '0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      xor_q    <= xor_d;
      hi_q     <= hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      wc_q     <= wc_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

  // Next-state and datapath update. Every receiving state advances only on
  // an accepted byte, so rx_valid gaps simply hold everything in place.
  always_comb begin
    state_d  = state_q;
    xor_d    = xor_q;
    hi_d     = hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    wc_d     = wc_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_H;
          xor_d   = 8'h00;
          idx_d   = '0;
          wc_d    = '0;
        end
      end
      LEN_H: begin
        if (accept) begin
          hi_d    = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = LEN_L;
        end
      end
      LEN_L: begin
        if (accept) begin
          xor_d = xor_q ^ rx_data;
          len_d = lenNew;
          // An empty frame or one larger than the memory is rejected
          // without consuming the rest of the stream.
          if (lenNew == 16'h0000 || lenNew > DepthW) begin
            state_d = ERROR;
          end else begin
            state_d = DATA_H;
          end
        end
      end
      DATA_H: begin
        if (accept) begin
          hi_d    = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = DATA_L;
        end
      end
      DATA_L: begin
        if (accept) begin
          xor_d    = xor_q ^ rx_data;
          wrData_d = {hi_q, rx_data};
          wrAddr_d = idx_q;
          wrEn_d   = 1'b1;
          idx_d    = idx_q + ADDR_W'(1);
          wc_d     = wc_q + ADDR_W'(1);
          if (idxNext16 == len_q) begin
            state_d = CSUM;
          end else begin
            state_d = DATA_H;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          xor_d = xor_q ^ rx_data;
          if ((xor_q ^ rx_data) == 8'h00) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded purely from the current state. The core is only
  // released after a clean load; a failed frame may have left partial
  // contents behind, so it keeps the core held.
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      LEN_H, LEN_L, DATA_H, DATA_L, CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERROR: begin
        err = 1'b1;
      end
      default: begin
        rx_ready = 1'b0;
      end
    endcase
  end

  assign wr_en      = wrEn_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed test bench for imem_loader. A frame-level model (byte position,
// length, running XOR) predicts every output each cycle; literal checks at
// the end of each scenario pin the model against hand-computed results.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 24;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] word_count;
  logic              cpu_hold;

  int testCount = 0;
  int failCount = 0;

  logic [7:0] frame[$];
  int         wrAddrQ[$];
  int         wrDataQ[$];

  // Frame-level model: phase 0 idle, 1 receiving, 2 done, 3 error
  int mPhase   = 0;
  int mPos     = 0;
  int mN       = 0;
  int mXor     = 0;
  int mHi      = 0;
  int mWc      = 0;
  int mWrPend  = 0;
  int mWrAddr  = 0;
  int mWrData  = 0;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count),
    .cpu_hold   (cpu_hold)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on each active edge, from the inputs that edge sees.
  // Progress through the frame is tracked as a byte position rather than
  // a state: position 1-2 is the length, 3..2N+2 the data, 2N+3 the checksum.
  always @(posedge clk) begin
    if (rst) begin
      mPhase  = 0;
      mWc     = 0;
      mWrPend = 0;
    end else begin
      mWrPend = 0;
      if (start && mPhase != 1) begin
        mPhase = 1;
        mPos   = 0;
        mXor   = 0;
        mWc    = 0;
      end else if (mPhase == 1 && rx_valid) begin
        mPos = mPos + 1;
        mXor = mXor ^ int'(rx_data);
        if (mPos == 1) begin
          mHi = int'(rx_data);
        end else if (mPos == 2) begin
          mN = mHi * 256 + int'(rx_data);
          if (mN == 0 || mN > DEPTH) mPhase = 3;
        end else if (mPos <= 2 + 2 * mN) begin
          if (mPos % 2 == 1) begin
            mHi = int'(rx_data);
          end else begin
            mWrPend = 1;
            mWrAddr = (mPos - 4) / 2;
            mWrData = mHi * 256 + int'(rx_data);
            mWc     = mWc + 1;
          end
        end else begin
          mPhase = (mXor == 0) ? 2 : 3;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rx_ready", int'(rx_ready), (mPhase == 1) ? 1 : 0);
      checkOutput("busy", int'(busy), (mPhase == 1) ? 1 : 0);
      checkOutput("done", int'(done), (mPhase == 2) ? 1 : 0);
      checkOutput("err", int'(err), (mPhase == 3) ? 1 : 0);
      checkOutput("cpu_hold", int'(cpu_hold), (mPhase == 2) ? 0 : 1);
      checkOutput("word_count", int'(word_count), mWc);
      checkOutput("wr_en", int'(wr_en), mWrPend);
      if (wr_en && mWrPend == 1) begin
        checkOutput("wr_addr", int'(wr_addr), mWrAddr);
        checkOutput("wr_data", int'(wr_data), mWrData);
      end
    end
    if (wr_en) begin
      wrAddrQ.push_back(int'(wr_addr));
      wrDataQ.push_back(int'(wr_data));
    end
  end

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends the bytes in 'frame'. mode 1 inserts gaps; startAt pulses start
  // together with that byte index (-1 for never).
  task automatic applyStimulus(input int mode, input int startAt);
    int waited;
    for (int i = 0; i < frame.size(); i++) begin
      if (mode == 1) begin
        if (i % 3 == 2) idleCycles(5);
        else if (i % 2 == 1) idleCycles(1);
      end
      rx_valid = 1'b1;
      rx_data  = frame[i];
      start    = (i == startAt);
      waited   = 0;
      while (!rx_ready && waited < 50) begin
        @(posedge clk); #1;
        start = 1'b0;
        waited++;
      end
      if (waited >= 50) begin
        checkOutput("acceptTimeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    rx_valid = 1'b0;
  endtask

  task automatic loadClean();
    frame = '{8'h00, 8'h03, 8'h99, 8'h01, 8'h9A, 8'h02, 8'h09, 8'hC0, 8'hCA};
  endtask

  task automatic checkCleanWrites(input string tag);
    checkOutput({tag, "_nwrites"}, wrAddrQ.size(), 3);
    if (wrAddrQ.size() == 3) begin
      checkOutput({tag, "_a0"}, wrAddrQ[0], 0);
      checkOutput({tag, "_d0"}, wrDataQ[0], 16'h9901);
      checkOutput({tag, "_a1"}, wrAddrQ[1], 1);
      checkOutput({tag, "_d1"}, wrDataQ[1], 16'h9A02);
      checkOutput({tag, "_a2"}, wrAddrQ[2], 2);
      checkOutput({tag, "_d2"}, wrDataQ[2], 16'h09C0);
    end
  endtask

  task automatic checkDoneStatus(input string tag);
    checkOutput({tag, "_done"}, int'(done), 1);
    checkOutput({tag, "_err"}, int'(err), 0);
    checkOutput({tag, "_wc"}, int'(word_count), 3);
    checkOutput({tag, "_hold"}, int'(cpu_hold), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"}, int'(rx_ready), 0);
    checkOutput({tag, "_wr_en"}, int'(wr_en), 0);
    checkOutput({tag, "_wr_addr"}, int'(wr_addr), 0);
    checkOutput({tag, "_wr_data"}, int'(wr_data), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_err"}, int'(err), 0);
    checkOutput({tag, "_wc"}, int'(word_count), 0);
    checkOutput({tag, "_hold"}, int'(cpu_hold), 1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetValues("reset");

    // Clean load
    $display("[TB] clean load");
    wrAddrQ.delete(); wrDataQ.delete();
    pulseStart();
    checkOutput("start_rx_ready", int'(rx_ready), 1);
    loadClean();
    applyStimulus(0, -1);
    checkDoneStatus("clean");
    checkCleanWrites("clean");

    // Start while in DONE
    $display("[TB] start in DONE");
    pulseStart();
    checkOutput("restart_done", int'(done), 0);
    checkOutput("restart_hold", int'(cpu_hold), 1);
    checkOutput("restart_busy", int'(busy), 1);
    checkOutput("restart_wc", int'(word_count), 0);

    // Bad checksum (already in LEN_H)
    $display("[TB] bad checksum");
    wrAddrQ.delete(); wrDataQ.delete();
    loadClean();
    frame[8] = 8'hCB;
    applyStimulus(0, -1);
    checkOutput("badcs_err", int'(err), 1);
    checkOutput("badcs_done", int'(done), 0);
    checkOutput("badcs_hold", int'(cpu_hold), 1);
    checkCleanWrites("badcs");

    // Zero length
    $display("[TB] bad length");
    wrAddrQ.delete(); wrDataQ.delete();
    pulseStart();
    frame = '{8'h00, 8'h00};
    applyStimulus(0, -1);
    checkOutput("len0_err", int'(err), 1);
    checkOutput("len0_ready", int'(rx_ready), 0);
    idleCycles(2);
    checkOutput("len0_nwrites", wrAddrQ.size(), 0);

    // Length one past the memory size
    pulseStart();
    frame = '{8'h00, 8'h19};
    applyStimulus(0, -1);
    checkOutput("len25_err", int'(err), 1);
    checkOutput("len25_ready", int'(rx_ready), 0);
    idleCycles(2);
    checkOutput("len25_nwrites", wrAddrQ.size(), 0);

    // Backpressure
    $display("[TB] backpressure");
    wrAddrQ.delete(); wrDataQ.delete();
    pulseStart();
    loadClean();
    applyStimulus(1, -1);
    checkDoneStatus("gaps");
    checkCleanWrites("gaps");

    // Reset while waiting for the LO byte of word 1
    $display("[TB] reset mid-frame");
    pulseStart();
    frame = '{8'h00, 8'h03, 8'h99, 8'h01, 8'h9A};
    applyStimulus(0, -1);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    start    = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    start    = 1'b0;
    checkResetValues("midrst");
    idleCycles(1);
    checkOutput("midrst_idle_ready", int'(rx_ready), 0);
    wrAddrQ.delete(); wrDataQ.delete();
    pulseStart();
    loadClean();
    applyStimulus(0, -1);
    checkDoneStatus("after_rst");
    checkCleanWrites("after_rst");

    // Start pulsed alongside the first data byte (DATA_H) is ignored
    $display("[TB] start in DATA_H");
    wrAddrQ.delete(); wrDataQ.delete();
    pulseStart();
    loadClean();
    applyStimulus(0, 2);
    checkDoneStatus("ign_start");
    checkCleanWrites("ign_start");

    idleCycles(3);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    failCount++;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
